ws_rx_decoder: RTL and testbench

WS_RX_DECODER -- requirements
Module: ws_rx_decoder

---
 rtl/ws_rx_decoder.sv | 260 ++++++++++++++++++++++++++
 tb/tb_ws_rx_decoder.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ws_rx_decoder.sv
// ws_rx_decoder
// WS2812 single-wire NRZ receiver. data_in is synchronized, each high pulse
// is timed against thresholds derived from CLKHZ and classified as a 0 or 1
// bit, bits are packed MSB-first into 24-bit GRB pixels, and a long low gap
// closes the frame.
//
// Build option: define WS_RX_ERRCNT_EN to add a 16-bit saturating err_cnt
// output counting pulse-width errors and frames closed mid-pixel.
//
// state | meaning
// ------+---------------------------------------------------------------
// SYNC  | lost or not yet locked; waiting for a full reset-length low gap
// ARMED | gap seen; next rising edge starts a new frame
// HIGH  | timing a high pulse (one bit)
// LOW   | timing the low after a bit; long enough closes the frame

module ws_rx_decoder #(
  parameter logic [31:0] CLKHZ  = 32'd50_000_000,
  parameter int          WS_NUM = 16
) (
  input  logic                      external_clk,
  input  logic                      external_rstn,
  input  logic                      data_in,
  output logic [23:0]               pix_data,
  output logic [$clog2(WS_NUM)-1:0] pix_index,
  output logic                      pix_valid,
  output logic                      frame_done,
  output logic [$clog2(WS_NUM):0]   frame_len,
  output logic                      frame_ovf
`ifdef WS_RX_ERRCNT_EN
  ,
  output logic [15:0]               err_cnt
`endif
);

  localparam int IW = $clog2(WS_NUM);
  localparam int LW = IW + 1;

  localparam logic [15:0] TH_MIN = 16'(CLKHZ / 32'd5_000_000);
  localparam logic [15:0] TH_BIT = 16'((64'(CLKHZ) * 64'd3) / 64'd5_000_000);
  localparam logic [15:0] TH_MAX = 16'(CLKHZ / 32'd1_000_000);
  localparam logic [15:0] TH_RST = 16'(CLKHZ / 32'd20_000);

  localparam logic [LW-1:0] PIX_MAX  = LW'(WS_NUM);
  localparam logic [4:0]    LAST_BIT = 5'd23;

  typedef enum logic [1:0] {
    SYNC  = 2'd0,
    ARMED = 2'd1,
    HIGH  = 2'd2,
    LOW   = 2'd3
  } state_t;

  logic [1:0]    sync_q, sync_d;
  logic          din;

  state_t        state_q, state_d;
  logic [15:0]   cnt_q, cnt_d;
  logic [15:0]   cnt_inc;
  logic [4:0]    bitcnt_q, bitcnt_d;
  logic [LW-1:0] pixcnt_q, pixcnt_d;
  logic [23:0]   word_q, word_d;
  logic          ovf_acc_q, ovf_acc_d;

  logic [23:0]   pix_data_q, pix_data_d;
  logic [IW-1:0] pix_index_q, pix_index_d;
  logic          pix_valid_q, pix_valid_d;
  logic          frame_done_q, frame_done_d;
  logic [LW-1:0] frame_len_q, frame_len_d;
  logic          frame_ovf_q, frame_ovf_d;

  logic          bit_v;
  logic [23:0]   word_new;

`ifdef WS_RX_ERRCNT_EN
  logic          err_ev;
  logic [15:0]   err_cnt_q, err_cnt_d;
`endif

  assign sync_d = {sync_q[0], data_in};
  assign din    = sync_q[1];

  // Width counter never wraps; a stuck line parks at all-ones.
  assign cnt_inc = (&cnt_q) ? cnt_q : cnt_q + 16'd1;

  // Next-state, pulse timing, bit packing and frame bookkeeping.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    bitcnt_d     = bitcnt_q;
    pixcnt_d     = pixcnt_q;
    word_d       = word_q;
    ovf_acc_d    = ovf_acc_q;
    pix_data_d   = pix_data_q;
    pix_index_d  = pix_index_q;
    pix_valid_d  = 1'b0;
    frame_done_d = 1'b0;
    frame_len_d  = frame_len_q;
    frame_ovf_d  = frame_ovf_q;
    bit_v        = (cnt_q >= TH_BIT);
    word_new     = {word_q[22:0], bit_v};
`ifdef WS_RX_ERRCNT_EN
    err_ev       = 1'b0;
`endif

    unique case (state_q)
      SYNC: begin
        if (din) begin
          cnt_d = 16'd0;
        end else if (cnt_inc >= TH_RST) begin
          state_d = ARMED;
          cnt_d   = 16'd0;
        end else begin
          cnt_d = cnt_inc;
        end
      end

      ARMED: begin
        if (din) begin
          state_d   = HIGH;
          cnt_d     = 16'd1;
          bitcnt_d  = 5'd0;
          pixcnt_d  = '0;
          word_d    = 24'd0;
          ovf_acc_d = 1'b0;
        end
      end

      HIGH: begin
        if (din) begin
          // Abort as soon as the pulse is too long rather than at its end.
          if (cnt_inc > TH_MAX) begin
            state_d = SYNC;
            cnt_d   = 16'd0;
`ifdef WS_RX_ERRCNT_EN
            err_ev  = 1'b1;
`endif
          end else begin
            cnt_d = cnt_inc;
          end
        end else if (cnt_q < TH_MIN || cnt_q > TH_MAX) begin
          // This falling-edge cycle already counts toward the resync gap.
          state_d = SYNC;
          cnt_d   = 16'd1;
`ifdef WS_RX_ERRCNT_EN
          err_ev  = 1'b1;
`endif
        end else begin
          state_d = LOW;
          cnt_d   = 16'd1;
          word_d  = word_new;
          if (bitcnt_q == LAST_BIT) begin
            bitcnt_d = 5'd0;
            if (pixcnt_q < PIX_MAX) begin
              pix_valid_d = 1'b1;
              pix_data_d  = word_new;
              pix_index_d = pixcnt_q[IW-1:0];
              pixcnt_d    = pixcnt_q + LW'(1);
            end else begin
              ovf_acc_d = 1'b1;
            end
          end else begin
            bitcnt_d = bitcnt_q + 5'd1;
          end
        end
      end

      LOW: begin
        if (din) begin
          state_d = HIGH;
          cnt_d   = 16'd1;
        end else if (cnt_inc >= TH_RST) begin
          state_d  = ARMED;
          cnt_d    = 16'd0;
          bitcnt_d = 5'd0;
          pixcnt_d = '0;
          if (bitcnt_q != 5'd0 || pixcnt_q != '0) begin
            frame_done_d = 1'b1;
            frame_len_d  = pixcnt_q;
            frame_ovf_d  = ovf_acc_q;
          end
`ifdef WS_RX_ERRCNT_EN
          if (bitcnt_q != 5'd0) begin
            err_ev = 1'b1;
          end
`endif
        end else begin
          cnt_d = cnt_inc;
        end
      end

      default: begin
        state_d = SYNC;
        cnt_d   = 16'd0;
      end
    endcase
  end

  // Synchronizer, FSM and output registers.
  always_ff @(posedge external_clk) begin
    if (!external_rstn) begin
      sync_q       <= 2'b00;
      state_q      <= SYNC;
      cnt_q        <= 16'd0;
      bitcnt_q     <= 5'd0;
      pixcnt_q     <= '0;
      word_q       <= 24'd0;
      ovf_acc_q    <= 1'b0;
      pix_data_q   <= 24'd0;
      pix_index_q  <= '0;
      pix_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
      frame_len_q  <= '0;
      frame_ovf_q  <= 1'b0;
    end else begin
      sync_q       <= sync_d;
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      bitcnt_q     <= bitcnt_d;
      pixcnt_q     <= pixcnt_d;
      word_q       <= word_d;
      ovf_acc_q    <= ovf_acc_d;
      pix_data_q   <= pix_data_d;
      pix_index_q  <= pix_index_d;
      pix_valid_q  <= pix_valid_d;
      frame_done_q <= frame_done_d;
      frame_len_q  <= frame_len_d;
      frame_ovf_q  <= frame_ovf_d;
    end
  end

`ifdef WS_RX_ERRCNT_EN
  // Saturating error count.
  always_comb begin
    err_cnt_d = err_cnt_q;
    if (err_ev && err_cnt_q != 16'hFFFF) begin
      err_cnt_d = err_cnt_q + 16'd1;
    end
  end

  // Error counter register.
  always_ff @(posedge external_clk) begin
    if (!external_rstn) begin
      err_cnt_q <= 16'd0;
    end else begin
      err_cnt_q <= err_cnt_d;
    end
  end

  assign err_cnt = err_cnt_q;
`endif

  assign pix_data   = pix_data_q;
  assign pix_index  = pix_index_q;
  assign pix_valid  = pix_valid_q;
  assign frame_done = frame_done_q;
  assign frame_len  = frame_len_q;
  assign frame_ovf  = frame_ovf_q;

endmodule

// File: tb/tb_ws_rx_decoder.sv
// Testbench for ws_rx_decoder: pulse-level reference model feeding a
// scoreboard of expected pixel/frame events, checked by an independent
// monitor on the falling clock edge.

module tb_ws_rx_decoder;

  localparam logic [31:0] CLKHZ  = 32'd20_000_000;
  localparam int          WS_NUM = 16;
  localparam int          IW     = $clog2(WS_NUM);

  // Timing rules in clock cycles at CLKHZ.
  localparam int TH_MIN = CLKHZ / 5_000_000;       // 0.2 us
  localparam int TH_BIT = CLKHZ * 3 / 5_000_000;   // 0.6 us
  localparam int TH_MAX = CLKHZ / 1_000_000;       // 1.0 us
  localparam int TH_RST = CLKHZ / 20_000;          // 50 us
  localparam int GAP    = TH_RST + 100;
  localparam int H0     = CLKHZ * 2 / 5_000_000;   // 0.4 us
  localparam int H1     = CLKHZ * 17 / 20_000_000; // 0.85 us
  localparam int PER    = CLKHZ / 800_000;         // 1.25 us
  localparam int GLITCH = CLKHZ / 10_000_000;      // 0.1 us

  logic            external_clk = 1'b0;
  logic            external_rstn = 1'b0;
  logic            data_in = 1'b0;
  logic [23:0]     pix_data;
  logic [IW-1:0]   pix_index;
  logic            pix_valid;
  logic            frame_done;
  logic [IW:0]     frame_len;
  logic            frame_ovf;
`ifdef WS_RX_ERRCNT_EN
  logic [15:0]     err_cnt;
`endif

  always #25 external_clk = ~external_clk;

  ws_rx_decoder #(.CLKHZ(CLKHZ), .WS_NUM(WS_NUM)) dut (
    .external_clk (external_clk),
    .external_rstn(external_rstn),
    .data_in      (data_in),
    .pix_data     (pix_data),
    .pix_index    (pix_index),
    .pix_valid    (pix_valid),
    .frame_done   (frame_done),
    .frame_len    (frame_len),
    .frame_ovf    (frame_ovf)
`ifdef WS_RX_ERRCNT_EN
    ,
    .err_cnt      (err_cnt)
`endif
  );

  typedef struct {
    bit          is_frame;
    logic [23:0] data;
    int          idx;
    int          len;
    bit          ovf;
  } ev_t;

  ev_t exp_q[$];
  ev_t mon_e;
  int  checks = 0;
  int  errors = 0;

  // Reference model state, advanced one whole pulse / low run at a time.
  bit          m_sync;
  int          m_bits, m_pix, m_low, m_err;
  logic [23:0] m_word;
  bit          m_ovf;

  function automatic void m_clear();
    m_bits = 0;
    m_pix  = 0;
    m_word = 24'd0;
    m_ovf  = 1'b0;
  endfunction

  function automatic void model_high(int h);
    ev_t e;
    m_low = 0;
    if (!m_sync) return;
    if (h < TH_MIN || h > TH_MAX) begin
      m_err++;
      m_sync = 1'b0;
      return;
    end
    m_word = {m_word[22:0], (h >= TH_BIT)};
    m_bits++;
    if (m_bits == 24) begin
      m_bits = 0;
      if (m_pix < WS_NUM) begin
        e.is_frame = 1'b0;
        e.data     = m_word;
        e.idx      = m_pix;
        e.len      = 0;
        e.ovf      = 1'b0;
        exp_q.push_back(e);
        m_pix++;
      end else begin
        m_ovf = 1'b1;
      end
    end
  endfunction

  function automatic void model_low(int l);
    ev_t e;
    m_low += l;
    if (m_low < TH_RST) return;
    if (!m_sync) begin
      m_sync = 1'b1;
      m_clear();
      return;
    end
    if (m_bits > 0 || m_pix > 0) begin
      e.is_frame = 1'b1;
      e.data     = 24'd0;
      e.idx      = 0;
      e.len      = m_pix;
      e.ovf      = m_ovf;
      exp_q.push_back(e);
      if (m_bits > 0) m_err++;
    end
    m_clear();
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic pulse(input int h, input int l);
    model_high(h);
    data_in = 1'b1;
    repeat (h) @(negedge external_clk);
    model_low(l);
    data_in = 1'b0;
    repeat (l) @(negedge external_clk);
  endtask

  task automatic idle(input int l);
    model_low(l);
    data_in = 1'b0;
    repeat (l) @(negedge external_clk);
  endtask

  task automatic send_bit(input bit b, input int l);
    int h;
    h = b ? int'($urandom_range(TH_BIT, TH_MAX)) : int'($urandom_range(TH_MIN, TH_BIT - 1));
    pulse(h, l);
  endtask

  task automatic send_word(input logic [23:0] w, input int nbits, input int last_low);
    for (int i = 0; i < nbits; i++)
      send_bit(w[23-i], (i == nbits - 1) ? last_low : int'($urandom_range(3, 10)));
  endtask

  task automatic send_word_fixed(input logic [23:0] w, input int last_low);
    int h;
    for (int i = 0; i < 24; i++) begin
      h = w[23-i] ? H1 : H0;
      pulse(h, (i == 23) ? last_low : PER - h);
    end
  endtask

  task automatic do_reset();
    external_rstn = 1'b0;
    data_in       = 1'b0;
    m_sync        = 1'b0;
    m_low         = 0;
    m_err         = 0;
    m_clear();
    repeat (4) @(negedge external_clk);
    chk("rst_pix_valid", pix_valid, 0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_frame_ovf", frame_ovf, 0);
    chk("rst_pix_data", pix_data, 0);
    chk("rst_pix_index", pix_index, 0);
    chk("rst_frame_len", frame_len, 0);
`ifdef WS_RX_ERRCNT_EN
    chk("rst_err_cnt", err_cnt, 0);
`endif
    external_rstn = 1'b1;
  endtask

  task automatic end_scn(input string name);
    idle(20);
    chk({name, "_pending"}, exp_q.size(), 0);
`ifdef WS_RX_ERRCNT_EN
    chk({name, "_err_cnt"}, err_cnt, m_err);
`endif
  endtask

  // Monitor: every strobe must match the head of the expected queue.
  always @(negedge external_clk) begin
    if (external_rstn && (pix_valid || frame_done)) begin
      checks++;
      if (pix_valid && frame_done) begin
        errors++;
        $display("FAIL both_strobes: pix_valid and frame_done together, required never");
      end else if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_strobe: pix_valid=%0b frame_done=%0b idx=%0d data=0x%06h, required none",
                 pix_valid, frame_done, pix_index, pix_data);
      end else begin
        mon_e = exp_q.pop_front();
        if (frame_done != mon_e.is_frame) begin
          errors++;
          $display("FAIL strobe_kind: got frame_done=%0b, required frame_done=%0b",
                   frame_done, mon_e.is_frame);
        end else if (!mon_e.is_frame &&
                     (pix_data !== mon_e.data || pix_index !== mon_e.idx[IW-1:0])) begin
          errors++;
          $display("FAIL pixel: got idx=%0d data=0x%06h, required idx=%0d data=0x%06h",
                   pix_index, pix_data, mon_e.idx, mon_e.data);
        end else if (mon_e.is_frame &&
                     (frame_len !== mon_e.len[IW:0] || frame_ovf !== mon_e.ovf)) begin
          errors++;
          $display("FAIL frame: got len=%0d ovf=%0b, required len=%0d ovf=%0b",
                   frame_len, frame_ovf, mon_e.len, mon_e.ovf);
        end
      end
    end
  end

  initial begin
    int  np, nb, tot, ep, l;
    bit  b;

    do_reset();

    // Reference frame with nominal WS2812 timing.
    idle(GAP);
    send_word_fixed(24'h00FF00, PER - H0);
    send_word_fixed(24'h123456, GAP);
    end_scn("basic");

    // Joining mid-stream after reset: nothing until a full gap.
    do_reset();
    send_word(24'h5A5A5A, 12, 5);
    send_word(24'hC3C3C3, 24, GAP);
    send_word(24'h0F1E2D, 24, 8);
    send_word(24'h3C4B5A, 24, GAP);
    end_scn("midjoin");

    // Overflow beyond WS_NUM pixels, then a clean frame clears frame_ovf.
    for (int p = 0; p < 17; p++) send_word(24'hA5A5A5, 24, (p == 16) ? GAP : 6);
    send_word(24'h010203, 24, GAP);
    end_scn("overflow");

    // Short glitch inside pixel 1, recovery after gap.
    send_word(24'h112233, 24, 7);
    send_word(24'h445566, 5, 5);
    pulse(GLITCH, 5);
    send_word(24'h778899, 18, GAP);
    send_word(24'hABCDEF, 24, GAP);
    end_scn("glitch");

    // Partial pixel closed by a gap.
    send_word(24'hFEDCBA, 12, GAP);
    end_scn("partial");

    // Gap one cycle short of reset length, then exactly reset length.
    send_word(24'h135790, 24, TH_RST - 1);
    send_word(24'h24680A, 24, TH_RST);
    end_scn("gap_edge");

    // Width boundaries: min, bit-1, bit, max -> 0,0,1,1 repeated.
    for (int i = 0; i < 6; i++) begin
      pulse(TH_MIN, 4);
      pulse(TH_BIT - 1, 4);
      pulse(TH_BIT, 4);
      pulse(TH_MAX, (i == 5) ? GAP : 4);
    end
    end_scn("widths");
    send_word(24'h9ABCDE, 10, 4);
    pulse(TH_MAX + 1, 4);
    send_word(24'h9ABCDE, 13, GAP);
    send_word(24'h0000FF, 24, GAP);
    end_scn("too_long");
    send_word(24'h9ABCDE, 3, 4);
    pulse(TH_MIN - 1, 4);
    send_word(24'h9ABCDE, 20, GAP);
    send_word(24'hFF0000, 24, GAP);
    end_scn("too_short");

    // Reset mid-frame abandons it; decoding resumes after a gap.
    send_word(24'hFFFFFF, 10, 5);
    do_reset();
    idle(GAP);
    send_word(24'h5555AA, 24, GAP);
    end_scn("reset_mid");

    // Randomized frames with optional partial tails and width errors.
    for (int f = 0; f < 8; f++) begin
      np  = int'($urandom_range(0, 2));
      nb  = ($urandom_range(0, 1) != 0) ? int'($urandom_range(1, 23)) : 0;
      tot = np * 24 + nb;
      ep  = ($urandom_range(0, 3) == 0 && tot > 0) ? int'($urandom_range(0, tot - 1)) : -1;
      for (int k = 0; k < tot; k++) begin
        b = 1'($urandom_range(0, 1));
        l = (k == tot - 1) ? GAP : int'($urandom_range(3, 10));
        if (k == ep)
          pulse(($urandom_range(0, 1) != 0) ? int'($urandom_range(1, TH_MIN - 1))
                                            : int'($urandom_range(TH_MAX + 1, TH_MAX + 10)), l);
        else
          send_bit(b, l);
      end
      if (tot == 0) idle(GAP);
      end_scn("random");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
